// File: rtl/sva_sched_pkg.sv
// Shared widths, FSM states, response codes and the slot payload for the thread scheduler.
package sva_sched_pkg;

    localparam int unsigned SLOTS   = 4;
    localparam int unsigned STATE_W = 8;
    localparam int unsigned TIMER_W = 16;
    localparam int unsigned CNT_W   = $clog2(SLOTS + 1);
    localparam int unsigned IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic [STATE_W-1:0] ST0 = STATE_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SP_ISSUE,
        ST_SP_WAIT,
        ST_COMMIT
    } ctrl_state_e;

    typedef enum logic [1:0] {
        RC_NONE = 2'b00,
        RC_SUCC = 2'b01,
        RC_FAIL = 2'b10,
        RC_LAZY = 2'b11
    } rsp_code_e;

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [TIMER_W-1:0] start;
    } slot_t;

endpackage

// File: rtl/sva_slot_table.sv
// Live-thread table: one combinational read port, one synchronous write port.
module sva_slot_table
    import sva_sched_pkg::*;
(
    input  logic             clk,
    input  logic [CNT_W-1:0] rd_idx,
    output slot_t            rd_slot,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_idx,
    input  slot_t            wr_slot
);

    // Contents are meaningful only below live_cnt, so the array carries no reset.
    slot_t mem_q [SLOTS];

    // Write the compacted or freshly spawned thread.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[IDX_W'(wr_idx)] <= wr_slot;
        end
    end

    assign rd_slot = mem_q[IDX_W'(rd_idx)];

endmodule

// File: rtl/sva_thread_sched.sv
// Per-tick scan of live assertion threads through a shared evaluator, with
// in-place compaction of survivors and one spawn from the start state.
module sva_thread_sched
    import sva_sched_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               tick,
    input  logic [TIMER_W-1:0] timer,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [STATE_W-1:0] req_state,
    output logic [TIMER_W-1:0] req_start,
    input  logic               rsp_valid,
    input  logic               rsp_active,
    input  logic [STATE_W-1:0] rsp_state,
    input  logic [1:0]         rsp_code,
    output logic               busy,
    output logic               succ,
    output logic               fail,
    output logic               lazy,
    output logic [CNT_W-1:0]   live_cnt,
    output logic               overflow,
    output logic               tick_missed
);

    ctrl_state_e        state_q, state_d;
    logic [CNT_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   wr_q, wr_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   live_cnt_q, live_cnt_d;
    logic               req_valid_q, req_valid_d;
    logic [STATE_W-1:0] req_state_q, req_state_d;
    logic [TIMER_W-1:0] req_start_q, req_start_d;
    logic               busy_q, busy_d;
    logic               succ_q, succ_d;
    logic               fail_q, fail_d;
    logic               lazy_q, lazy_d;
    logic               overflow_q, overflow_d;
    logic               tick_missed_q, tick_missed_d;

    logic               rsp_fire;
    logic               tbl_wr_en;
    slot_t              tbl_wr_slot;
    slot_t              tbl_rd_slot;

    // Read address runs one step ahead so the request payload can be registered.
    sva_slot_table u_table (
        .clk     (sys_clk),
        .rd_idx  (rd_d),
        .rd_slot (tbl_rd_slot),
        .wr_en   (tbl_wr_en),
        .wr_idx  (wr_q),
        .wr_slot (tbl_wr_slot)
    );

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            rd_q          <= '0;
            wr_q          <= '0;
            n_q           <= '0;
            live_cnt_q    <= '0;
            req_valid_q   <= 1'b0;
            req_state_q   <= '0;
            req_start_q   <= '0;
            busy_q        <= 1'b0;
            succ_q        <= 1'b0;
            fail_q        <= 1'b0;
            lazy_q        <= 1'b0;
            overflow_q    <= 1'b0;
            tick_missed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            n_q           <= n_d;
            live_cnt_q    <= live_cnt_d;
            req_valid_q   <= req_valid_d;
            req_state_q   <= req_state_d;
            req_start_q   <= req_start_d;
            busy_q        <= busy_d;
            succ_q        <= succ_d;
            fail_q        <= fail_d;
            lazy_q        <= lazy_d;
            overflow_q    <= overflow_d;
            tick_missed_q <= tick_missed_d;
        end
    end

    // Next-state, index bookkeeping, table write-back and event decode.
    always_ff @(posedge sys_clk) begin end
    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        n_d           = n_q;
        live_cnt_d    = live_cnt_q;
        overflow_d    = overflow_q;
        tick_missed_d = tick_missed_q;
        succ_d        = 1'b0;
        fail_d        = 1'b0;
        lazy_d        = 1'b0;
        rsp_fire      = 1'b0;
        tbl_wr_en     = 1'b0;
        tbl_wr_slot   = '0;

        if (tick && (state_q != ST_IDLE)) begin
            tick_missed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    rd_d    = '0;
                    wr_d    = '0;
                    n_d     = live_cnt_q;
                    state_d = (live_cnt_q != '0) ? ST_ISSUE : ST_SP_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    rsp_fire = 1'b1;
                    // wr never passes rd, so this cannot clobber an unread thread.
                    if (rsp_active) begin
                        tbl_wr_en         = 1'b1;
                        tbl_wr_slot.state = rsp_state;
                        tbl_wr_slot.start = req_start_q;
                        wr_d              = wr_q + CNT_W'(1);
                    end
                    rd_d    = rd_q + CNT_W'(1);
                    state_d = ((rd_q + CNT_W'(1)) == n_q) ? ST_SP_ISSUE : ST_ISSUE;
                end
            end
            ST_SP_ISSUE: begin
                if (req_ready) begin
                    state_d = ST_SP_WAIT;
                end
            end
            ST_SP_WAIT: begin
                if (rsp_valid) begin
                    rsp_fire = 1'b1;
                    if (rsp_active) begin
                        if (wr_q < CNT_W'(SLOTS)) begin
                            tbl_wr_en         = 1'b1;
                            tbl_wr_slot.state = rsp_state;
                            tbl_wr_slot.start = req_start_q;
                            wr_d              = wr_q + CNT_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                live_cnt_d = wr_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rsp_fire) begin
            case (rsp_code_e'(rsp_code))
                RC_SUCC: succ_d = 1'b1;
                RC_FAIL: fail_d = 1'b1;
                RC_LAZY: lazy_d = 1'b1;
                default: ;
            endcase
        end
    end

    // Request payload: loaded on entry to an issue state and held until accepted.
    always_comb begin
        req_state_d = req_state_q;
        req_start_d = req_start_q;
        req_valid_d = (state_d == ST_ISSUE) || (state_d == ST_SP_ISSUE);
        busy_d      = (state_d != ST_IDLE);

        if ((state_d == ST_ISSUE) && (state_q != ST_ISSUE)) begin
            req_state_d = tbl_rd_slot.state;
            req_start_d = tbl_rd_slot.start;
        end
        if ((state_d == ST_SP_ISSUE) && (state_q != ST_SP_ISSUE)) begin
            req_state_d = ST0;
            req_start_d = timer;
        end
    end

    assign req_valid   = req_valid_q;
    assign req_state   = req_state_q;
    assign req_start   = req_start_q;
    assign busy        = busy_q;
    assign succ        = succ_q;
    assign fail        = fail_q;
    assign lazy        = lazy_q;
    assign live_cnt    = live_cnt_q;
    assign overflow    = overflow_q;
    assign tick_missed = tick_missed_q;

endmodule

// File: tb/tb_sva_thread_sched.sv
// Directed bench for the thread scheduler: spawn, retire, compaction, overflow,
// stall, missed tick, stray response and mid-scan reset.
module tb_sva_thread_sched;
    import sva_sched_pkg::*;

    logic               sys_clk;
    logic               sys_rst_n;
    logic               tick;
    logic [TIMER_W-1:0] timer;
    logic               req_valid;
    logic               req_ready;
    logic [STATE_W-1:0] req_state;
    logic [TIMER_W-1:0] req_start;
    logic               rsp_valid;
    logic               rsp_active;
    logic [STATE_W-1:0] rsp_state;
    logic [1:0]         rsp_code;
    logic               busy;
    logic               succ;
    logic               fail;
    logic               lazy;
    logic [CNT_W-1:0]   live_cnt;
    logic               overflow;
    logic               tick_missed;

    int vectors    = 0;
    int miscompares = 0;

    // Cycle counters of high outputs, sampled mid-cycle.
    int busy_cyc = 0;
    int succ_cyc = 0;
    int fail_cyc = 0;
    int lazy_cyc = 0;

    // Per-scan stimulus (index n is the spawn) and captured requests.
    logic [STATE_W-1:0] nst  [5];
    logic [1:0]         cds  [5];
    logic [STATE_W-1:0] gst  [5];
    logic [TIMER_W-1:0] gts  [5];

    sva_thread_sched dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .tick        (tick),
        .timer       (timer),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_state   (req_state),
        .req_start   (req_start),
        .rsp_valid   (rsp_valid),
        .rsp_active  (rsp_active),
        .rsp_state   (rsp_state),
        .rsp_code    (rsp_code),
        .busy        (busy),
        .succ        (succ),
        .fail        (fail),
        .lazy        (lazy),
        .live_cnt    (live_cnt),
        .overflow    (overflow),
        .tick_missed (tick_missed)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (busy === 1'b1) busy_cyc++;
        if (succ === 1'b1) succ_cyc++;
        if (fail === 1'b1) fail_cyc++;
        if (lazy === 1'b1) lazy_cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // Evaluator stand-in: accept one request, answer the cycle after the handshake.
    task automatic serve(input logic act, input logic [STATE_W-1:0] ns, input logic [1:0] cd,
                         output logic [STATE_W-1:0] got_st, output logic [TIMER_W-1:0] got_ts);
        int t = 0;
        while (req_valid !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        if (req_valid !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL req_valid_timeout: req_valid=%b, required 1 within 50 cycles", req_valid);
        end
        got_st    = req_state;
        got_ts    = req_start;
        req_ready = 1'b1;
        step();
        req_ready  = 1'b0;
        rsp_valid  = 1'b1;
        rsp_active = act;
        rsp_state  = ns;
        rsp_code   = cd;
        step();
        rsp_valid  = 1'b0;
        rsp_active = 1'b0;
        rsp_state  = '0;
        rsp_code   = 2'b00;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 100) begin
            step();
            t++;
        end
        if (busy !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy=%b, required 0 within 100 cycles", busy);
        end
    endtask

    // Tick, then serve n live threads and the spawn with act[i]/nst[i]/cds[i].
    task automatic run_scan(input int n, input logic [4:0] act);
        logic [STATE_W-1:0] s;
        logic [TIMER_W-1:0] ts;
        do_tick();
        for (int i = 0; i <= n; i++) begin
            serve(act[i], nst[i], cds[i], s, ts);
            gst[i] = s;
            gts[i] = ts;
        end
        wait_idle();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) step();
        vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if ({succ, fail, lazy} !== 3'b000) begin miscompares++; $display("FAIL reset_events: got %b expected 000", {succ, fail, lazy}); end
        vectors++; if (live_cnt !== CNT_W'(0)) begin miscompares++; $display("FAIL reset_live_cnt: got %0d expected 0", live_cnt); end
        vectors++; if ({overflow, tick_missed} !== 2'b00) begin miscompares++; $display("FAIL reset_sticky: got %b expected 00", {overflow, tick_missed}); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        vectors++; if (busy !== 1'b0 || req_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: busy=%b req_valid=%b expected 0 0", busy, req_valid); end
    endtask

    task automatic test_spawn_empty();
        int b0 = busy_cyc;
        int e0 = succ_cyc + fail_cyc + lazy_cyc;
        timer  = 16'h0100;
        nst[0] = 8'h01; cds[0] = 2'b00;
        run_scan(0, 5'b00001);
        vectors++; if (gst[0] !== ST0) begin miscompares++; $display("FAIL spawn_state: got %h expected %h", gst[0], ST0); end
        vectors++; if (gts[0] !== 16'h0100) begin miscompares++; $display("FAIL spawn_start: got %h expected 0100", gts[0]); end
        vectors++; if (busy_cyc - b0 !== 3) begin miscompares++; $display("FAIL spawn_busy_cycles: got %0d expected 3", busy_cyc - b0); end
        vectors++; if (succ_cyc + fail_cyc + lazy_cyc - e0 !== 0) begin miscompares++; $display("FAIL spawn_events: got %0d expected 0", succ_cyc + fail_cyc + lazy_cyc - e0); end
        vectors++; if (live_cnt !== CNT_W'(1)) begin miscompares++; $display("FAIL spawn_live_cnt: got %0d expected 1", live_cnt); end
    endtask

    task automatic test_succ_retire();
        int b0 = busy_cyc;
        int s0 = succ_cyc;
        int f0 = fail_cyc;
        timer  = 16'h0200;
        nst[0] = 8'h00; cds[0] = 2'b01;
        nst[1] = 8'h01; cds[1] = 2'b00;
        run_scan(1, 5'b00010);
        vectors++; if (gst[0] !== 8'h01 || gts[0] !== 16'h0100) begin miscompares++; $display("FAIL retire_thread_req: got %h/%h expected 01/0100", gst[0], gts[0]); end
        vectors++; if (gst[1] !== 8'h00 || gts[1] !== 16'h0200) begin miscompares++; $display("FAIL retire_spawn_req: got %h/%h expected 00/0200", gst[1], gts[1]); end
        vectors++; if (succ_cyc - s0 !== 1) begin miscompares++; $display("FAIL retire_succ_pulse: got %0d cycles expected 1", succ_cyc - s0); end
        vectors++; if (fail_cyc - f0 !== 0) begin miscompares++; $display("FAIL retire_no_fail: got %0d cycles expected 0", fail_cyc - f0); end
        vectors++; if (busy_cyc - b0 !== 5) begin miscompares++; $display("FAIL retire_busy_cycles: got %0d expected 5", busy_cyc - b0); end
        vectors++; if (live_cnt !== CNT_W'(1)) begin miscompares++; $display("FAIL retire_live_cnt: got %0d expected 1", live_cnt); end
    endtask

    task automatic test_compaction();
        int b0, s0, f0, l0;
        logic [STATE_W-1:0] exp_st [4];
        logic [TIMER_W-1:0] exp_ts [4];
        // Table holds {01,0200}; grow it to three threads.
        timer  = 16'h0300;
        nst[0] = 8'h11; cds[0] = 2'b00;
        nst[1] = 8'h12; cds[1] = 2'b00;
        run_scan(1, 5'b00011);
        vectors++; if (gst[0] !== 8'h01 || gts[0] !== 16'h0200) begin miscompares++; $display("FAIL slot0_after_retire: got %h/%h expected 01/0200", gst[0], gts[0]); end
        timer  = 16'h0400;
        nst[0] = 8'h21; nst[1] = 8'h22; nst[2] = 8'h23;
        cds[0] = 2'b00; cds[1] = 2'b00; cds[2] = 2'b00;
        run_scan(2, 5'b00111);
        vectors++; if (live_cnt !== CNT_W'(3)) begin miscompares++; $display("FAIL grow_live_cnt: got %0d expected 3", live_cnt); end
        // Middle thread fails; spawn retires silently.
        b0 = busy_cyc; s0 = succ_cyc; f0 = fail_cyc; l0 = lazy_cyc;
        timer  = 16'h0500;
        nst[0] = 8'h31; cds[0] = 2'b00;
        nst[1] = 8'h00; cds[1] = 2'b10;
        nst[2] = 8'h33; cds[2] = 2'b00;
        nst[3] = 8'h00; cds[3] = 2'b00;
        run_scan(3, 5'b00101);
        exp_st = '{8'h21, 8'h22, 8'h23, 8'h00};
        exp_ts = '{16'h0200, 16'h0300, 16'h0400, 16'h0500};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (gst[i] !== exp_st[i] || gts[i] !== exp_ts[i]) begin
                miscompares++;
                $display("FAIL compact_req%0d: got %h/%h expected %h/%h", i, gst[i], gts[i], exp_st[i], exp_ts[i]);
            end
        end
        vectors++; if (fail_cyc - f0 !== 1) begin miscompares++; $display("FAIL compact_fail_pulse: got %0d cycles expected 1", fail_cyc - f0); end
        vectors++; if (succ_cyc - s0 !== 0 || lazy_cyc - l0 !== 0) begin miscompares++; $display("FAIL compact_other_events: got succ %0d lazy %0d expected 0 0", succ_cyc - s0, lazy_cyc - l0); end
        vectors++; if (busy_cyc - b0 !== 9) begin miscompares++; $display("FAIL compact_busy_cycles: got %0d expected 9", busy_cyc - b0); end
        vectors++; if (live_cnt !== CNT_W'(2)) begin miscompares++; $display("FAIL compact_live_cnt: got %0d expected 2", live_cnt); end
    endtask

    task automatic test_tick_missed();
        int b0 = busy_cyc;
        int l0 = lazy_cyc;
        logic [STATE_W-1:0] s;
        logic [TIMER_W-1:0] ts;
        timer = 16'h0600;
        vectors++; if (tick_missed !== 1'b0) begin miscompares++; $display("FAIL tick_missed_pre: got %b expected 0", tick_missed); end
        do_tick();
        do_tick();
        serve(1'b1, 8'h41, 2'b00, s, ts);
        vectors++; if (s !== 8'h31 || ts !== 16'h0200) begin miscompares++; $display("FAIL survivor0: got %h/%h expected 31/0200", s, ts); end
        serve(1'b1, 8'h43, 2'b11, s, ts);
        vectors++; if (s !== 8'h33 || ts !== 16'h0400) begin miscompares++; $display("FAIL survivor1: got %h/%h expected 33/0400", s, ts); end
        serve(1'b1, 8'h44, 2'b00, s, ts);
        vectors++; if (s !== 8'h00 || ts !== 16'h0600) begin miscompares++; $display("FAIL missed_spawn_req: got %h/%h expected 00/0600", s, ts); end
        wait_idle();
        vectors++; if (tick_missed !== 1'b1) begin miscompares++; $display("FAIL tick_missed_set: got %b expected 1", tick_missed); end
        vectors++; if (lazy_cyc - l0 !== 1) begin miscompares++; $display("FAIL lazy_pulse: got %0d cycles expected 1", lazy_cyc - l0); end
        vectors++; if (busy_cyc - b0 !== 8) begin miscompares++; $display("FAIL missed_busy_cycles: got %0d expected 8", busy_cyc - b0); end
        vectors++; if (live_cnt !== CNT_W'(3)) begin miscompares++; $display("FAIL missed_live_cnt: got %0d expected 3", live_cnt); end
    endtask

    task automatic test_overflow_stall();
        int b0;
        logic [STATE_W-1:0] s;
        logic [TIMER_W-1:0] ts;
        // Fill the table: {51,0200} {53,0400} {54,0600} {55,0700}.
        timer  = 16'h0700;
        nst[0] = 8'h51; nst[1] = 8'h53; nst[2] = 8'h54; nst[3] = 8'h55;
        cds[0] = 2'b00; cds[1] = 2'b00; cds[2] = 2'b00; cds[3] = 2'b00;
        run_scan(3, 5'b01111);
        vectors++; if (live_cnt !== CNT_W'(4) || overflow !== 1'b0) begin miscompares++; $display("FAIL full_table: live_cnt %0d overflow %b expected 4 0", live_cnt, overflow); end
        b0 = busy_cyc;
        timer = 16'h0800;
        do_tick();
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (req_valid !== 1'b1 || req_state !== 8'h51 || req_start !== 16'h0200) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got %b/%h/%h expected 1/51/0200", c, req_valid, req_state, req_start);
            end
            step();
        end
        serve(1'b1, 8'h61, 2'b00, s, ts);
        serve(1'b1, 8'h62, 2'b00, s, ts);
        vectors++; if (s !== 8'h53) begin miscompares++; $display("FAIL full_req1: got %h expected 53", s); end
        serve(1'b1, 8'h63, 2'b00, s, ts);
        serve(1'b1, 8'h64, 2'b00, s, ts);
        vectors++; if (s !== 8'h55 || ts !== 16'h0700) begin miscompares++; $display("FAIL full_req3: got %h/%h expected 55/0700", s, ts); end
        serve(1'b1, 8'h65, 2'b00, s, ts);
        wait_idle();
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_set: got %b expected 1", overflow); end
        vectors++; if (live_cnt !== CNT_W'(4)) begin miscompares++; $display("FAIL overflow_live_cnt: got %0d expected 4", live_cnt); end
        vectors++; if (busy_cyc - b0 !== 16) begin miscompares++; $display("FAIL stall_busy_cycles: got %0d expected 16", busy_cyc - b0); end
    endtask

    task automatic test_stray_rsp();
        int s0 = succ_cyc;
        rsp_valid = 1'b1; rsp_active = 1'b1; rsp_state = 8'h77; rsp_code = 2'b01;
        step();
        rsp_valid = 1'b0; rsp_active = 1'b0; rsp_state = '0; rsp_code = 2'b00;
        step();
        vectors++; if (succ_cyc - s0 !== 0) begin miscompares++; $display("FAIL stray_rsp_event: got %0d cycles expected 0", succ_cyc - s0); end
        vectors++; if (live_cnt !== CNT_W'(4) || busy !== 1'b0) begin miscompares++; $display("FAIL stray_rsp_state: live_cnt %0d busy %b expected 4 0", live_cnt, busy); end
    endtask

    task automatic test_reset_mid();
        int b0;
        timer = 16'h0900;
        do_tick();
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        vectors++; if (busy !== 1'b1 || req_valid !== 1'b0) begin miscompares++; $display("FAIL in_wait: busy %b req_valid %b expected 1 0", busy, req_valid); end
        sys_rst_n = 1'b0;
        #1;
        vectors++; if ({req_valid, busy, succ, fail, lazy, overflow, tick_missed} !== 7'b0) begin miscompares++; $display("FAIL async_reset_flags: got %b expected 0000000", {req_valid, busy, succ, fail, lazy, overflow, tick_missed}); end
        vectors++; if (live_cnt !== CNT_W'(0) || req_state !== 8'h00 || req_start !== 16'h0000) begin miscompares++; $display("FAIL async_reset_data: got %0d/%h/%h expected 0/00/0000", live_cnt, req_state, req_start); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        b0 = busy_cyc;
        timer  = 16'h0A00;
        nst[0] = 8'h07; cds[0] = 2'b00;
        run_scan(0, 5'b00001);
        vectors++; if (gst[0] !== ST0 || gts[0] !== 16'h0A00) begin miscompares++; $display("FAIL post_reset_spawn: got %h/%h expected 00/0A00", gst[0], gts[0]); end
        vectors++; if (busy_cyc - b0 !== 3) begin miscompares++; $display("FAIL post_reset_busy: got %0d expected 3", busy_cyc - b0); end
        vectors++; if (live_cnt !== CNT_W'(1)) begin miscompares++; $display("FAIL post_reset_live_cnt: got %0d expected 1", live_cnt); end
    endtask

    initial begin
        tick       = 1'b0;
        timer      = '0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_active = 1'b0;
        rsp_state  = '0;
        rsp_code   = 2'b00;
        for (int i = 0; i < 5; i++) begin
            nst[i] = '0;
            cds[i] = 2'b00;
            gst[i] = '0;
            gts[i] = '0;
        end
        test_reset();
        test_spawn_empty();
        test_succ_retire();
        test_compaction();
        test_tick_missed();
        test_overflow_stall();
        test_stray_rsp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
